// File: rtl/ycc_pkg.sv
// Shared widths, records and state encodings for the 4:2:2 -> 4:4:4 chroma path.
package ycc_pkg;

   localparam int DATA_WIDTH = 8;

   // Mid-scale chroma, i.e. zero colour difference.
   localparam logic [DATA_WIDTH-1:0] CHROMA_NEUTRAL = DATA_WIDTH'(1 << (DATA_WIDTH-1));

   // Output pixels are packed {Cr, Cb, Y} from MSB to LSB.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] y0;
      logic [DATA_WIDTH-1:0] cb;
      logic [DATA_WIDTH-1:0] y1;
      logic [DATA_WIDTH-1:0] cr;
      logic                  sof;
      logic                  last;
   } pair_t;

   typedef enum logic {A_EVEN, A_ODD} asm_state_t;
   typedef enum logic {EVEN, ODD} phase_t;

endpackage

// File: rtl/ycc_pair_fifo2.sv
// Two-entry pair queue: head/nxt visible, push and pop in one cycle, and a
// mark input that sets the line-end flag (bit 0) of the newest entry.
module ycc_pair_fifo2 #(
   parameter int W = 34
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   input  logic         mark,
   output logic [1:0]   count,
   output logic [W-1:0] head,
   output logic [W-1:0] nxt
);

   logic [W-1:0] mem0, mem1, n0, n1;
   logic [1:0]   cnt, ncnt;

   always_comb begin
      n0   = mem0;
      n1   = mem1;
      ncnt = cnt;
      case ({push, pop})
         2'b10: begin
            if (cnt == 2'd0) n0 = push_data;
            else             n1 = push_data;
            ncnt = cnt + 2'd1;
         end
         2'b01: begin
            n0   = mem1;
            ncnt = cnt - 2'd1;
         end
         2'b11: begin
            if (cnt == 2'd1) begin
               n0 = push_data;
            end else begin
               n0 = mem1;
               n1 = push_data;
            end
         end
         default: ;
      endcase
      // The mark lands on whichever slot holds the newest entry after this cycle.
      if (mark) begin
         if (ncnt == 2'd1)      n0[0] = 1'b1;
         else if (ncnt == 2'd2) n1[0] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= 2'd0;
         mem0 <= '0;
         mem1 <= '0;
      end else begin
         cnt  <= ncnt;
         mem0 <= n0;
         mem1 <= n1;
      end
   end

   assign count = cnt;
   assign head  = mem0;
   assign nxt   = mem1;

endmodule

// File: rtl/chroma_422_to_444.sv
// 4:2:2 -> 4:4:4 upsampler with valid/ready on both sides. Define CHROMA_INTERP_EN
// to average odd-pixel chroma across pairs; otherwise the pair's chroma is replicated.
module chroma_422_to_444
   import ycc_pkg::*;
#(
   parameter int DATA_WIDTH = ycc_pkg::DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [2*DATA_WIDTH-1:0] s_data,
   input  logic                    s_user,
   input  logic                    s_last,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [3*DATA_WIDTH-1:0] m_data,
   output logic                    m_user,
   output logic                    m_last,
   output logic                    err_odd_line
);

   localparam int DW = DATA_WIDTH;
`ifdef CHROMA_INTERP_EN
   localparam bit         INTERP = 1'b1;
   localparam logic [1:0] QDEPTH = 2'd2;
`else
   localparam bit         INTERP = 1'b0;
   localparam logic [1:0] QDEPTH = 2'd1;
`endif

   typedef struct packed {
      logic [DW-1:0] y0;
      logic [DW-1:0] cb;
      logic [DW-1:0] y1;
      logic [DW-1:0] cr;
      logic          sof;
      logic          last;
   } line_pair_t;
   localparam int PW = $bits(line_pair_t);

   asm_state_t    a_state;
   phase_t        phase;
   logic [DW-1:0] y0_q, cb_q;
   logic          sof_q;
   logic [1:0]    count;
   logic [PW-1:0] head_raw, nxt_raw, push_pair;
   line_pair_t    head, nxt;
   logic          accept, push, pop, mark, load;
   logic          head_ok, odd_ok, replicate;
   logic [DW-1:0] odd_cb, odd_cr;
   logic          unused_nxt_bits;

   function automatic logic [DW-1:0] avg(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0] s;
      s = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, 1'b1};
      return s[DW:1];
   endfunction

   // Valid/ready: a beat moves on a clock edge where valid and ready are both high;
   // valid and its payload never depend on ready from the same side.
   assign s_ready   = !rst && (a_state == A_EVEN || count < QDEPTH);
   assign accept    = s_valid && s_ready;
   assign push      = accept && a_state == A_ODD;
   assign mark      = accept && a_state == A_EVEN && s_last;
   assign push_pair = {y0_q, cb_q, s_data[DW-1:0], s_data[2*DW-1:DW], sof_q, s_last};

   ycc_pair_fifo2 #(.W(PW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_pair),
      .pop       (pop),
      .mark      (mark),
      .count     (count),
      .head      (head_raw),
      .nxt       (nxt_raw)
   );

   assign head = head_raw;
   assign nxt  = nxt_raw;
   assign unused_nxt_bits = ^{nxt.y0, nxt.y1, nxt.sof, nxt.last};

   always_ff @(posedge clk) begin
      if (rst) begin
         a_state      <= A_EVEN;
         y0_q         <= '0;
         cb_q         <= DW'(CHROMA_NEUTRAL);
         sof_q        <= 1'b0;
         err_odd_line <= 1'b0;
      end else begin
         err_odd_line <= mark;
         if (accept) begin
            case (a_state)
               A_EVEN: if (!s_last) begin
                  y0_q    <= s_data[DW-1:0];
                  cb_q    <= s_data[2*DW-1:DW];
                  sof_q   <= s_user;
                  a_state <= A_ODD;
               end
               A_ODD:   a_state <= A_EVEN;
               default: a_state <= A_EVEN;
            endcase
         end
      end
   end

   // A pair closing its line is never averaged with whatever follows.
   assign head_ok   = count != 2'd0;
   assign odd_ok    = head_ok && (!INTERP || head.last || count == 2'd2);
   assign replicate = !INTERP || head.last;
   assign odd_cb    = replicate ? head.cb : avg(head.cb, nxt.cb);
   assign odd_cr    = replicate ? head.cr : avg(head.cr, nxt.cr);
   assign load      = (!m_valid || m_ready) && (phase == EVEN ? head_ok : odd_ok);
   assign pop       = load && phase == ODD;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_user  <= 1'b0;
         m_last  <= 1'b0;
         phase   <= EVEN;
      end else if (load) begin
         m_valid <= 1'b1;
         if (phase == EVEN) begin
            m_data <= {head.cr, head.cb, head.y0};
            m_user <= head.sof;
            m_last <= 1'b0;
            phase  <= ODD;
         end else begin
            m_data <= {odd_cr, odd_cb, head.y1};
            m_user <= 1'b0;
            m_last <= head.last;
            phase  <= EVEN;
         end
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_chroma_422_to_444.sv
// Directed bench for chroma_422_to_444; expected pixels follow CHROMA_INTERP_EN.
module tb_chroma_422_to_444;

   localparam int DW = 8;
   localparam int EW = 3*DW + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid, s_ready, s_user, s_last;
   logic [2*DW-1:0] s_data;
   logic          m_valid, m_ready, m_user, m_last, err_odd_line;
   logic [3*DW-1:0] m_data;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] got_q[$];
   int            n_checks = 0;
   int            n_errors = 0;
   int            err_pulses = 0;
   logic [3*DW-1:0] bp_held;
   bit            bp_stable, bp_dropped;
   int            bp_n;

   always #5 clk = ~clk;

   chroma_422_to_444 #(.DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_user       (s_user),
      .s_last       (s_last),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_user       (m_user),
      .m_last       (m_last),
      .err_odd_line (err_odd_line)
   );

   // Output beats are sampled half a cycle before the edge that accepts them.
   always @(negedge clk) begin
      if (m_valid && m_ready) got_q.push_back({m_user, m_last, m_data});
      if (err_odd_line) err_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [EW-1:0] px(input bit u, input bit l, input int y, input int cb, input int cr);
      return {u, l, 8'(cr), 8'(cb), 8'(y)};
   endfunction

   task automatic send(input int y, input int c, input bit user, input bit last);
      int n = 0;
      s_valid = 1'b1;
      s_data  = {8'(c), 8'(y)};
      s_user  = user;
      s_last  = last;
      @(negedge clk);
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) check("send_timeout", {31'b0, s_ready}, 32'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_user  = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (got_q.size() < exp_q.size() && n < 300) begin
         @(posedge clk);
         n++;
      end
      repeat (6) @(posedge clk);
      #1;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++)
         check($sformatf("%s_px%0d", tag, i), 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic basic_line(input string tag);
      send(16, 100, 1'b1, 1'b0);
      send(17, 200, 1'b0, 1'b0);
      send(18, 110, 1'b0, 1'b0);
      send(19, 210, 1'b0, 1'b1);
      exp_q.push_back(px(1, 0, 16, 100, 200));
`ifdef CHROMA_INTERP_EN
      exp_q.push_back(px(0, 0, 17, 105, 205));
`else
      exp_q.push_back(px(0, 0, 17, 100, 200));
`endif
      exp_q.push_back(px(0, 0, 18, 110, 210));
      exp_q.push_back(px(0, 1, 19, 110, 210));
      drain(tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_user = 1'b0; s_last = 1'b0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", {31'b0, s_ready}, 32'd0);
      check("rst_m_valid", {31'b0, m_valid}, 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_m_user_last", {30'b0, m_user, m_last}, 32'd0);
      check("rst_err", {31'b0, err_odd_line}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_s_ready", {31'b0, s_ready}, 32'd1);

      basic_line("basic");

      // Rounding of the pair average: (100+101+1)>>1=101, (50+53+1)>>1=52.
      send(1, 100, 1'b1, 1'b0);
      send(2, 50, 1'b0, 1'b0);
      send(3, 101, 1'b0, 1'b0);
      send(4, 53, 1'b0, 1'b1);
      exp_q.push_back(px(1, 0, 1, 100, 50));
`ifdef CHROMA_INTERP_EN
      exp_q.push_back(px(0, 0, 2, 101, 52));
`else
      exp_q.push_back(px(0, 0, 2, 100, 50));
`endif
      exp_q.push_back(px(0, 0, 3, 101, 53));
      exp_q.push_back(px(0, 1, 4, 101, 53));
      drain("round");

      // Backpressure: downstream stalls 10 clocks right after the first output.
      bp_stable = 1'b1;
      bp_dropped = 1'b0;
      bp_n = 0;
      fork
         begin
            for (int p = 0; p < 4; p++) begin
               send(40 + 2*p, 10 + 20*p, p == 0, 1'b0);
               send(41 + 2*p, 20 + 20*p, 1'b0, p == 3);
            end
         end
         begin
            while (!m_valid && bp_n < 100) begin
               @(posedge clk);
               #1;
               bp_n++;
            end
            check("bp_first_valid", {31'b0, m_valid}, 32'd1);
            m_ready = 1'b0;
            bp_held = m_data;
            repeat (10) begin
               @(posedge clk);
               #1;
               if (m_data !== bp_held || !m_valid) bp_stable = 1'b0;
               if (s_valid && !s_ready) bp_dropped = 1'b1;
            end
            m_ready = 1'b1;
            check("bp_stable", {31'b0, bp_stable}, 32'd1);
            check("bp_s_ready_drop", {31'b0, bp_dropped}, 32'd1);
         end
      join
      for (int p = 0; p < 4; p++) begin
         exp_q.push_back(px(p == 0, 0, 40 + 2*p, 10 + 20*p, 20 + 20*p));
`ifdef CHROMA_INTERP_EN
         if (p < 3) exp_q.push_back(px(0, 0, 41 + 2*p, 20 + 20*p, 30 + 20*p));
         else       exp_q.push_back(px(0, 1, 47, 70, 80));
`else
         exp_q.push_back(px(0, p == 3, 41 + 2*p, 10 + 20*p, 20 + 20*p));
`endif
      end
      drain("bp");

      // Odd-length line: the third beat carries last and is dropped.
      err_pulses = 0;
      send(60, 90, 1'b1, 1'b0);
      send(61, 95, 1'b0, 1'b0);
      send(62, 99, 1'b0, 1'b1);
      exp_q.push_back(px(1, 0, 60, 90, 95));
      exp_q.push_back(px(0, 1, 61, 90, 95));
      drain("odd");
      check("odd_err_pulse", err_pulses, 32'd1);
      basic_line("after_odd");

      // Reset mid-line: pixel 0 of the completed pair may leave, nothing else.
      send(70, 1, 1'b1, 1'b0);
      send(71, 2, 1'b0, 1'b0);
      send(72, 3, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_m_valid", {31'b0, m_valid}, 32'd0);
      check("mid_rst_s_ready", {31'b0, s_ready}, 32'd0);
      rst = 1'b0;
      exp_q.push_back(px(1, 0, 70, 1, 2));
      drain("mid_rst");
      basic_line("after_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
